// File: rtl/car_motion_ctrl.sv
// Player car position controller, updated once per frame at vsync fall.
// Optional feature macro: CAR_ACCEL_EN (hold-to-accelerate step doubling).
module car_motion_ctrl #(
  parameter int WIDTH  = 10,
  parameter int X_MIN  = 200,
  parameter int X_MAX  = 346,
  parameter int X_INIT = 270,
  parameter int Y_POS  = 300,
  parameter int STEP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             btn_left,
  input  logic             btn_right,
  output logic [WIDTH-1:0] car_x,
  output logic [WIDTH-1:0] car_y,
  output logic             frame_tick,
  output logic             moving
);

  typedef enum logic {WAIT_FRAME, UPDATE} state_t;

  localparam logic [WIDTH:0] XMIN_W = (WIDTH+1)'(X_MIN);
  localparam logic [WIDTH:0] XMAX_W = (WIDTH+1)'(X_MAX);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  state_t           state, state_nx;
  logic             vs_s1, vs_s2, vs_prev;
  logic             bl_s1, bl_s2, br_s1, br_s2;
  logic             go_left, go_right;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   x_wide;
  logic [WIDTH-1:0] x_nx;

  assign car_y    = WIDTH'(Y_POS);
  assign go_left  = bl_s2 & ~br_s2;
  assign go_right = br_s2 & ~bl_s2;

  // Synchronize async inputs and register the vsync falling-edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_prev    <= 1'b1;
      bl_s1      <= 1'b0;
      bl_s2      <= 1'b0;
      br_s1      <= 1'b0;
      br_s2      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_s1      <= vs;
      vs_s2      <= vs_s1;
      vs_prev    <= vs_s2;
      bl_s1      <= btn_left;
      bl_s2      <= bl_s1;
      br_s1      <= btn_right;
      br_s2      <= br_s1;
      frame_tick <= vs_prev & ~vs_s2;
    end
  end

`ifdef CAR_ACCEL_EN
  logic [2:0] hold_cnt;
  logic [1:0] last_dir;
  logic [1:0] dir;

  assign dir  = {go_left, go_right};
  assign step = hold_cnt[2] ? (STEP_W << 1) : STEP_W;

  // Count consecutive updates in the same direction; any change restarts
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 3'd0;
      last_dir <= 2'b00;
    end else if (state == UPDATE) begin
      last_dir <= dir;
      if (dir == 2'b00 || dir != last_dir)
        hold_cnt <= 3'd0;
      else if (hold_cnt != 3'd7)
        hold_cnt <= hold_cnt + 3'd1;
    end
  end
`else
  assign step = STEP_W;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_nx;
  end

  // Next state: one UPDATE cycle per detected frame
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_FRAME: if (frame_tick) state_nx = UPDATE;
      UPDATE:     state_nx = WAIT_FRAME;
      default:    state_nx = WAIT_FRAME;
    endcase
  end

  // Target position with clamping done one bit wider than the output
  always_comb begin
    x_wide = {1'b0, car_x};
    x_nx   = car_x;
    if (go_left) begin
      if (x_wide < XMIN_W + step) x_nx = WIDTH'(XMIN_W);
      else                        x_nx = WIDTH'(x_wide - step);
    end else if (go_right) begin
      if (x_wide + step > XMAX_W) x_nx = WIDTH'(XMAX_W);
      else                        x_nx = WIDTH'(x_wide + step);
    end
  end

  // Commit position and motion flag only in the UPDATE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      car_x  <= WIDTH'(X_INIT);
      moving <= 1'b0;
    end else if (state == UPDATE) begin
      car_x  <= x_nx;
      moving <= (x_nx != car_x);
    end
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl; checks latency, clamps, reset.
// Accelerated-step expectations apply when CAR_ACCEL_EN is defined.
module tb_car_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst, vs, btn_left, btn_right;
  logic [9:0] car_x, car_y;
  logic       frame_tick, moving;

  int n_cmp = 0;
  int n_err = 0;
  int ticks = 0;
  int t0;

  car_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vs         (vs),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .car_x      (car_x),
    .car_y      (car_y),
    .frame_tick (frame_tick),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vs = 1'b1;
    btn_left = 1'b0;
    btn_right = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One vsync pulse; samples frame_tick each cycle
  task automatic frame();
    @(negedge clk);
    vs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (frame_tick) ticks++;
    end
    vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // n frames in one direction, idle frame after every 4 keeps step at 2
  task automatic move(input logic l, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      btn_left = l;
      btn_right = r;
      frame();
      if (i % 4 == 3 || i == n - 1) begin
        btn_left = 1'b0;
        btn_right = 1'b0;
        frame();
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    vs = 1'b1;
    btn_left = 1'b0;
    btn_right = 1'b0;

    do_reset();
    chk("rst_x", car_x, 270);
    chk("rst_y", car_y, 300);
    chk("rst_mov", moving, 0);
    chk("rst_tick", frame_tick, 0);

    t0 = ticks;
    repeat (10) frame();
    chk("idle_x", car_x, 270);
    chk("idle_mov", moving, 0);
    chk("idle_ticks", ticks - t0, 10);

    // Latency: vs falls before edge N
    btn_right = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    @(posedge clk); #1;
    chk("lat_n_tick", frame_tick, 0);
    @(posedge clk); #1;
    chk("lat_n1_tick", frame_tick, 0);
    @(posedge clk); #1;
    chk("lat_n2_tick", frame_tick, 1);
    chk("lat_n2_x", car_x, 270);
    @(posedge clk); #1;
    chk("lat_n3_tick", frame_tick, 0);
    chk("lat_n3_x", car_x, 270);
    @(posedge clk); #1;
    chk("lat_n4_x", car_x, 272);
    chk("lat_n4_mov", moving, 1);
    vs = 1'b1;
    btn_right = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("lat_hold_x", car_x, 272);

    // Left clamp
    do_reset();
    move(1'b1, 1'b0, 34);
    chk("lclamp_pre_x", car_x, 202);
    btn_left = 1'b1;
    frame();
    chk("lclamp1_x", car_x, 200);
    chk("lclamp1_mov", moving, 1);
    frame();
    chk("lclamp2_x", car_x, 200);
    chk("lclamp2_mov", moving, 0);
    btn_left = 1'b0;

    // Right clamp
    do_reset();
    move(1'b0, 1'b1, 37);
    chk("rclamp_pre_x", car_x, 344);
    btn_right = 1'b1;
    frame();
    chk("rclamp1_x", car_x, 346);
    chk("rclamp1_mov", moving, 1);
    frame();
    chk("rclamp2_x", car_x, 346);
    chk("rclamp2_mov", moving, 0);

    // Both buttons
    btn_left = 1'b1;
    btn_right = 1'b1;
    t0 = ticks;
    repeat (3) frame();
    chk("both_x", car_x, 346);
    chk("both_mov", moving, 0);
    chk("both_ticks", ticks - t0, 3);
    btn_left = 1'b0;
    btn_right = 1'b0;

    // Reset during the UPDATE cycle
    do_reset();
    btn_right = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    vs = 1'b1;
    @(posedge clk); #1;
    chk("rmid_x", car_x, 270);
    chk("rmid_mov", moving, 0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rmid_after_x", car_x, 270);
    frame();
    chk("rmid_next_x", car_x, 272);

    // Long hold right from 270
    do_reset();
    btn_right = 1'b1;
    frame(); chk("hold1_x", car_x, 272);
    frame(); chk("hold2_x", car_x, 274);
    frame(); chk("hold3_x", car_x, 276);
    frame(); chk("hold4_x", car_x, 278);
    frame(); chk("hold5_x", car_x, 280);
    frame();
`ifdef CAR_ACCEL_EN
    chk("hold6_x", car_x, 284);
    btn_right = 1'b0;
    frame();
    chk("rel_x", car_x, 284);
    chk("rel_mov", moving, 0);
    btn_right = 1'b1;
    frame();
    chk("repress_x", car_x, 286);
`else
    chk("hold6_x", car_x, 282);
    btn_right = 1'b0;
    frame();
    chk("rel_x", car_x, 282);
    chk("rel_mov", moving, 0);
    btn_right = 1'b1;
    frame();
    chk("repress_x", car_x, 284);
`endif
    chk("repress_mov", moving, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
